// File: rtl/serial_somador_subtrator_if.sv
// Handshake and operand/result bus of the serial adder/subtractor.
// The master issues requests; the slave (the arithmetic unit) returns results and flags.
interface serial_somador_subtrator_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Result;
   logic             C_out;
   logic             V;
   logic             Z;

   modport master (output start, A, B, sub, input busy, done, Result, C_out, V, Z);
   modport slave  (input start, A, B, sub, output busy, done, Result, C_out, V, Z);
endinterface

// File: rtl/serial_somador_subtrator.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock, LSB first, WIDTH/DIGIT cycles per op.
// Operands latch on an accepted start; Result/C_out/V/Z hold until the next completion.
module serial_somador_subtrator #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   serial_somador_subtrator_if.slave   bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_sh_q, res_sh_d, result_q, result_d;
   logic             carry_q, carry_d, c_q, c_d, v_q, v_d, z_q, z_d, done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [DIGIT:0]   sum;
   logic [WIDTH-1:0] res_next;
   logic             msb_cin;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      c_d      = c_q;
      v_d      = v_q;
      z_d      = z_q;
      done_d   = 1'b0;

      sum      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      res_next = WIDTH'({sum[DIGIT-1:0], res_sh_q} >> DIGIT);
      // Carry into the top bit of the chunk, recovered from its sum bit; only meaningful on the final chunk.
      msb_cin  = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1];

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = RUN;
               a_d      = bus.A;
               b_d      = bus.B ^ {WIDTH{bus.sub}};
               carry_d  = bus.sub;
               cnt_d    = '0;
               res_sh_d = '0;
            end
         end
         RUN: begin
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            carry_d  = sum[DIGIT];
            res_sh_d = res_next;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = IDLE;
               result_d = res_next;
               c_d      = sum[DIGIT];
               v_d      = msb_cin ^ sum[DIGIT];
               z_d      = (res_next == '0);
               done_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         c_q      <= c_d;
         v_q      <= v_d;
         z_q      <= z_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = (state_q == RUN);
   assign bus.done   = done_q;
   assign bus.Result = result_q;
   assign bus.C_out  = c_q;
   assign bus.V      = v_q;
   assign bus.Z      = z_q;
endmodule
